// File: rtl/lsu_tlul_host.sv
// TL-UL host adapter for the core LSU data port. Issues A-channel requests from
// core requests and returns in-order D-channel responses, flagging tag mismatches.

package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic [3:0] instr_type;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   localparam tl_a_user_t TL_A_USER_DEFAULT = '{
      instr_type: 4'h9,
      cmd_intg:   7'h00,
      data_intg:  7'h00
   };

   typedef struct packed {
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      tl_d_user_t  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module lsu_tlul_host
   import tlul_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned TagW           = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output tl_h2d_t     tl_o,
   input  tl_d2h_t     tl_i,
   output logic        proto_err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [TagW-1:0] TagLast = TagW'(MaxOutstanding - 1);

   logic [CntW-1:0] cnt, cnt_d;
   logic [TagW-1:0] iss_tag, iss_tag_d;
   logic [TagW-1:0] ret_tag, ret_tag_d;
   logic            proto_err, proto_err_d;

   logic a_valid;
   logic gnt;
   logic rsp;
   logic src_mismatch;
   logic unexpected;

   function automatic logic [TagW-1:0] tag_inc(input logic [TagW-1:0] tag);
      return (tag == TagLast) ? '0 : tag + TagW'(1);
   endfunction

   // Handshakes are gated by rst_ni so nothing is granted or returned while reset is held.
   assign a_valid      = rst_ni && data_req_i && (cnt < CntMax);
   assign gnt          = a_valid && tl_i.a_ready;
   assign rsp          = rst_ni && tl_i.d_valid && (cnt != '0);
   assign unexpected   = rst_ni && tl_i.d_valid && (cnt == '0);
   assign src_mismatch = (tl_i.d_source != 8'(ret_tag));

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      tl_o           = '0;
      tl_o.a_valid   = a_valid;
      tl_o.a_param   = 3'h0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = 8'(iss_tag);
      tl_o.a_address = {data_addr_i[31:2], 2'b00};
      tl_o.a_data    = data_wdata_i;
      tl_o.a_user    = TL_A_USER_DEFAULT;
      tl_o.d_ready   = 1'b1;
      if (!data_we_i) begin
         tl_o.a_opcode = Get;
         tl_o.a_mask   = 4'hF;
      end else if (data_be_i == 4'hF) begin
         tl_o.a_opcode = PutFullData;
         tl_o.a_mask   = data_be_i;
      end else begin
         tl_o.a_opcode = PutPartialData;
         tl_o.a_mask   = data_be_i;
      end
   end

   always_comb begin
      cnt_d       = cnt;
      iss_tag_d   = iss_tag;
      ret_tag_d   = ret_tag;
      proto_err_d = proto_err;
      unique case ({gnt, rsp})
         2'b10:   cnt_d = cnt + CntW'(1);
         2'b01:   cnt_d = cnt - CntW'(1);
         default: cnt_d = cnt;
      endcase
      if (gnt) begin
         iss_tag_d = tag_inc(iss_tag);
      end
      if (rsp) begin
         ret_tag_d = tag_inc(ret_tag);
      end
      if (unexpected || (rsp && src_mismatch)) begin
         proto_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_ni) begin
         cnt       <= '0;
         iss_tag   <= '0;
         ret_tag   <= '0;
         proto_err <= 1'b0;
      end else begin
         cnt       <= cnt_d;
         iss_tag   <= iss_tag_d;
         ret_tag   <= ret_tag_d;
         proto_err <= proto_err_d;
      end
   end

   assign data_gnt_o    = gnt;
   assign data_rvalid_o = rsp;
   assign data_rdata_o  = tl_i.d_data;
   assign data_err_o    = rsp && (tl_i.d_error || src_mismatch);
   assign proto_err_o   = proto_err;

   // Response fields the core interface has no use for.
   logic unused_inputs;
   assign unused_inputs = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink,
                            tl_i.d_user, data_addr_i[1:0]};

endmodule

// File: tb/tb_lsu_tlul_host.sv
// Self-checking bench for lsu_tlul_host: A-channel decode vectors plus a scoreboard
// of expected responses for pipelined, stalled, error and reset sequences.

module tb_lsu_tlul_host;
   import tlul_pkg::*;

   localparam int MaxOut = 2;

   logic        clk_i;
   logic        rst_ni;
   logic        data_req_i;
   logic        data_gnt_o;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;
   logic        proto_err_o;

   lsu_tlul_host #(.MaxOutstanding(MaxOut), .TagW(2)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .data_req_i    (data_req_i),
      .data_gnt_o    (data_gnt_o),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .data_err_o    (data_err_o),
      .tl_o          (tl_o),
      .tl_i          (tl_i),
      .proto_err_o   (proto_err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      tl_a_op_e    op;
      logic [3:0]  mask;
      logic [31:0] exp_addr;
   } vec_t;

   typedef struct packed {
      logic [7:0]  tag;
      logic [31:0] data;
   } rsp_t;

   vec_t vecs[5];
   rsp_t exp_q[$];
   rsp_t dev_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int m_cnt    = 0;
   int m_iss    = 0;
   logic m_perr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dev_data(input logic [31:0] addr);
      return (addr == 32'h0000_0104) ? 32'hDEAD_BEEF : {addr[15:0], ~addr[15:0]};
   endfunction

   // One clock cycle: drive, check at the falling edge against the model, update the model.
   task automatic cycle(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic a_ready, input logic d_valid, input logic [7:0] d_source,
                        input logic [31:0] d_data, input logic d_error);
      logic exp_gnt;
      logic exp_rv;
      rsp_t e;
      rsp_t n;
      data_req_i    = req;
      data_we_i     = we;
      data_be_i     = be;
      data_addr_i   = addr;
      data_wdata_i  = wdata;
      tl_i.a_ready  = a_ready;
      tl_i.d_valid  = d_valid;
      tl_i.d_source = d_source;
      tl_i.d_data   = d_data;
      tl_i.d_error  = d_error;
      @(negedge clk_i);
      exp_gnt = req && a_ready && (m_cnt < MaxOut);
      exp_rv  = d_valid && (m_cnt > 0);
      check("a_valid", tl_o.a_valid, req && (m_cnt < MaxOut));
      check("gnt", data_gnt_o, exp_gnt);
      check("rvalid", data_rvalid_o, exp_rv);
      check("proto_err", proto_err_o, m_perr);
      if (exp_gnt) check("a_source", tl_o.a_source, 8'(m_iss));
      if (d_valid && m_cnt == 0) m_perr = 1'b1;
      if (exp_rv) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: response with no expected entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("rdata", data_rdata_o, e.data);
            check("err", data_err_o, d_error || (d_source != e.tag));
            if (d_source != e.tag) m_perr = 1'b1;
            m_cnt--;
         end
      end
      if (exp_gnt) begin
         n.tag  = 8'(m_iss);
         n.data = dev_data(addr);
         exp_q.push_back(n);
         dev_q.push_back(n);
         m_cnt++;
         m_iss = (m_iss + 1) % MaxOut;
      end
      @(posedge clk_i);
      #1;
   endtask

   // Load request plus an optional well-formed response to the oldest pending grant.
   task automatic run(input logic req, input logic [31:0] addr, input logic a_ready,
                      input logic resp);
      rsp_t r;
      r.tag  = 8'h00;
      r.data = 32'h0;
      if (resp && dev_q.size() > 0) r = dev_q.pop_front();
      cycle(req, 1'b0, 4'hF, addr, 32'h0, a_ready, resp, r.tag, r.data, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rsp_t r;
      vecs[0] = '{1'b0, 4'h0, 32'h0000_0104, 32'h1111_2222, Get,            4'hF, 32'h0000_0104};
      vecs[1] = '{1'b1, 4'h4, 32'h0000_0203, 32'h00AB_0000, PutPartialData, 4'h4, 32'h0000_0200};
      vecs[2] = '{1'b1, 4'hF, 32'h1000_0007, 32'hCAFE_F00D, PutFullData,    4'hF, 32'h1000_0004};
      vecs[3] = '{1'b1, 4'h3, 32'hFFFF_FFFE, 32'h0000_5A5A, PutPartialData, 4'h3, 32'hFFFF_FFFC};
      vecs[4] = '{1'b0, 4'h1, 32'h0000_0003, 32'h0,         Get,            4'hF, 32'h0000_0000};

      // Reset with a request, ready and response all asserted: nothing may leak out.
      tl_i          = '0;
      rst_ni        = 1'b0;
      data_req_i    = 1'b1;
      data_we_i     = 1'b0;
      data_be_i     = 4'hF;
      data_addr_i   = 32'h40;
      data_wdata_i  = 32'h0;
      tl_i.a_ready  = 1'b1;
      tl_i.d_valid  = 1'b1;
      @(negedge clk_i);
      check("rst_gnt", data_gnt_o, 1'b0);
      check("rst_rvalid", data_rvalid_o, 1'b0);
      check("rst_proto_err", proto_err_o, 1'b0);
      check("rst_cnt", 32'(dut.cnt), 32'd0);
      check("rst_iss_tag", 32'(dut.iss_tag), 32'd0);
      check("rst_ret_tag", 32'(dut.ret_tag), 32'd0);
      @(posedge clk_i);
      #1;
      data_req_i   = 1'b0;
      tl_i.d_valid = 1'b0;
      tl_i.a_ready = 1'b0;
      rst_ni       = 1'b1;

      // A-channel decode vectors, presented without a_ready so no state changes.
      for (int i = 0; i < 5; i++) begin
         data_req_i   = 1'b1;
         data_we_i    = vecs[i].we;
         data_be_i    = vecs[i].be;
         data_addr_i  = vecs[i].addr;
         data_wdata_i = vecs[i].wdata;
         #1;
         check("vec_a_valid", tl_o.a_valid, 1'b1);
         check("vec_gnt", data_gnt_o, 1'b0);
         check("vec_opcode", tl_o.a_opcode, vecs[i].op);
         check("vec_mask", tl_o.a_mask, vecs[i].mask);
         check("vec_address", tl_o.a_address, vecs[i].exp_addr);
         check("vec_data", tl_o.a_data, vecs[i].wdata);
         check("vec_size", tl_o.a_size, 2'd2);
         check("vec_source", tl_o.a_source, 8'd0);
         check("vec_d_ready", tl_o.d_ready, 1'b1);
      end
      data_req_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Single load with a one-cycle response.
      run(1'b1, 32'h0000_0104, 1'b1, 1'b0);
      run(1'b0, 32'h0, 1'b1, 1'b1);

      // Byte store then word store, each answered the next cycle.
      cycle(1'b1, 1'b1, 4'b0100, 32'h0000_0203, 32'h00AB_0000, 1'b1, 1'b0, 8'h0, 32'h0, 1'b0);
      run(1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 4'hF, 32'h0000_0300, 32'h1234_5678, 1'b1, 1'b0, 8'h0, 32'h0, 1'b0);
      run(1'b0, 32'h0, 1'b1, 1'b1);

      // Outstanding limit: third load held off until the first response arrives.
      run(1'b1, 32'h0000_1000, 1'b1, 1'b0);
      run(1'b1, 32'h0000_1004, 1'b1, 1'b0);
      run(1'b1, 32'h0000_1008, 1'b1, 1'b0);
      run(1'b1, 32'h0000_1008, 1'b1, 1'b0);
      run(1'b1, 32'h0000_1008, 1'b1, 1'b1);
      run(1'b1, 32'h0000_1008, 1'b1, 1'b0);
      run(1'b0, 32'h0, 1'b1, 1'b1);
      run(1'b0, 32'h0, 1'b1, 1'b1);

      // Ten pipelined loads: grant and response coincide at cnt == 1.
      run(1'b1, 32'h0000_2000, 1'b1, 1'b0);
      for (int i = 1; i < 10; i++) begin
         run(1'b1, 32'h0000_2000 + 32'(i * 4), 1'b1, 1'b1);
      end
      run(1'b0, 32'h0, 1'b1, 1'b1);
      check("pipe_cnt_drained", 32'(dut.cnt), 32'd0);

      // d_error response: err set, protocol error stays clear.
      run(1'b1, 32'h0000_3000, 1'b1, 1'b0);
      r = dev_q.pop_front();
      cycle(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, r.tag, r.data, 1'b1);
      run(1'b0, 32'h0, 1'b1, 1'b0);

      // Wrong source tag: err set and a sticky protocol error.
      run(1'b1, 32'h0000_3100, 1'b1, 1'b0);
      r = dev_q.pop_front();
      cycle(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, r.tag ^ 8'h01, r.data, 1'b0);
      run(1'b0, 32'h0, 1'b1, 1'b0);
      run(1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset mid-burst with two loads outstanding.
      run(1'b1, 32'h0000_4000, 1'b1, 1'b0);
      run(1'b1, 32'h0000_4004, 1'b1, 1'b0);
      check("burst_cnt", 32'(dut.cnt), 32'd2);
      data_req_i    = 1'b1;
      tl_i.a_ready  = 1'b1;
      tl_i.d_valid  = 1'b1;
      tl_i.d_source = 8'h00;
      #2;
      rst_ni = 1'b0;
      #1;
      check("mid_rst_gnt", data_gnt_o, 1'b0);
      check("mid_rst_rvalid", data_rvalid_o, 1'b0);
      check("mid_rst_proto_err", proto_err_o, 1'b0);
      check("mid_rst_cnt", 32'(dut.cnt), 32'd0);
      check("mid_rst_iss_tag", 32'(dut.iss_tag), 32'd0);
      m_cnt  = 0;
      m_iss  = 0;
      m_perr = 1'b0;
      exp_q.delete();
      dev_q.delete();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Stale response after reset is unexpected; the new load uses source 0.
      cycle(1'b1, 1'b0, 4'hF, 32'h0000_5000, 32'h0, 1'b1, 1'b1, 8'h01, 32'hBAD0_BAD0, 1'b0);
      run(1'b0, 32'h0, 1'b1, 1'b1);
      run(1'b0, 32'h0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
